// File: rtl/blkdev_seq.sv
// blkdev_seq: multi-block command sequencer for the block-device pi1 command port.
// Each block runs status polls, a READ or WRITE command and a buffer SWAP, handing
// the data buffer to a local consumer/producer through buf_rdy_o/buf_ack_i.
// Optional feature macro: BLKDEV_SEQ_TIMEOUT_EN bounds each status poll to TIMEOUT
// consecutive non-READY cycles.
module blkdev_seq #(
  parameter int unsigned ARCHBITSZ = 32,
  parameter int unsigned CNTBITSZ  = 16,
  parameter int unsigned TIMEOUT   = 65535,
  localparam int unsigned ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic                     req_wr_i,
  input  logic [ARCHBITSZ-1:0]     req_blk_i,
  input  logic [CNTBITSZ-1:0]      req_cnt_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [ARCHBITSZ-1:0]     blk_o,
  output logic                     buf_rdy_o,
  input  logic                     buf_ack_i,
  output logic [1:0]               pi_op_o,
  output logic [ADDRBITSZ-1:0]     pi_addr_o,
  output logic [ARCHBITSZ-1:0]     pi_data_o,
  input  logic [ARCHBITSZ-1:0]     pi_data_i,
  output logic [ARCHBITSZ/8-1:0]   pi_sel_o,
  input  logic                     pi_rdy_i
);

  typedef enum logic [2:0] {
    StIdle,
    StStat,
    StRead,
    StWrite,
    StSwap,
    StBuf,
    StFin
  } state_e;

  localparam logic [1:0]           OpNoop    = 2'b00;
  localparam logic [1:0]           OpRw      = 2'b11;
  localparam logic [ADDRBITSZ-1:0] CmdStatus = ADDRBITSZ'(0);
  localparam logic [ADDRBITSZ-1:0] CmdSwap   = ADDRBITSZ'(1);
  localparam logic [ADDRBITSZ-1:0] CmdRead   = ADDRBITSZ'(2);
  localparam logic [ADDRBITSZ-1:0] CmdWrite  = ADDRBITSZ'(3);
  localparam logic [ARCHBITSZ-1:0] StatReady = ARCHBITSZ'(1);
  localparam logic [ARCHBITSZ-1:0] StatError = ARCHBITSZ'(3);

  state_e                r_state, w_state;
  state_e                r_nxt, w_nxt;
  logic                  r_last, w_last;   // current STAT is the write-completion poll
  logic                  r_wr, w_wr;
  logic [ARCHBITSZ-1:0]  r_blk, w_blk;
  logic [CNTBITSZ-1:0]   r_rem, w_rem;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  r_err, w_err;
  logic                  w_blk_done;
  logic                  w_poll_exp;

`ifdef BLKDEV_SEQ_TIMEOUT_EN
  localparam int unsigned PollW = $clog2(TIMEOUT + 1);

  logic [PollW-1:0] r_poll;

  assign w_poll_exp = (r_poll == PollW'(TIMEOUT - 1));

  // Count consecutive STAT cycles; any entry from another state restarts the count.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_poll <= '0;
    end else if (r_state == StStat && w_state == StStat) begin
      r_poll <= r_poll + PollW'(1);
    end else begin
      r_poll <= '0;
    end
  end
`else
  assign w_poll_exp = 1'b0;
`endif

  // Next-state and request bookkeeping.
  always_comb begin
    w_state    = r_state;
    w_nxt      = r_nxt;
    w_last     = r_last;
    w_wr       = r_wr;
    w_blk      = r_blk;
    w_rem      = r_rem;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_err      = r_err;
    w_blk_done = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (req_i) begin
          w_wr   = req_wr_i;
          w_blk  = req_blk_i;
          w_rem  = req_cnt_i;
          w_err  = 1'b0;
          w_busy = 1'b1;
          w_last = 1'b0;
          if (req_cnt_i == '0) begin
            w_state = StFin;
          end else if (req_wr_i) begin
            w_state = StBuf;
          end else begin
            w_state = StStat;
            w_nxt   = StRead;
          end
        end
      end
      StStat: begin
        if (pi_rdy_i && pi_data_i == StatReady) begin
          if (r_last) begin
            w_blk_done = 1'b1;
          end else begin
            w_state = r_nxt;
          end
        end else if (pi_rdy_i && pi_data_i == StatError) begin
          w_err   = 1'b1;
          w_state = StFin;
        end else if (w_poll_exp) begin
          w_err   = 1'b1;
          w_state = StFin;
        end
      end
      StRead: begin
        if (pi_rdy_i) begin
          w_state = StStat;
          w_nxt   = StSwap;
        end
      end
      StSwap: begin
        if (pi_rdy_i) begin
          if (r_wr) begin
            w_state = StStat;
            w_nxt   = StWrite;
          end else begin
            w_state = StBuf;
          end
        end
      end
      StWrite: begin
        if (pi_rdy_i) begin
          w_state = StStat;
          w_last  = 1'b1;
        end
      end
      StBuf: begin
        if (buf_ack_i) begin
          if (r_wr) begin
            w_state = StStat;
            w_nxt   = StSwap;
          end else begin
            w_blk_done = 1'b1;
          end
        end
      end
      StFin: begin
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_state = StIdle;
      end
      default: w_state = StIdle;
    endcase

    // Block finished: advance the block number and either start the next one or finish.
    if (w_blk_done) begin
      w_blk  = r_blk + ARCHBITSZ'(1);
      w_rem  = r_rem - CNTBITSZ'(1);
      w_last = 1'b0;
      if (r_rem == CNTBITSZ'(1)) begin
        w_state = StFin;
      end else if (r_wr) begin
        w_state = StBuf;
      end else begin
        w_state = StStat;
        w_nxt   = StRead;
      end
    end
  end

  // State and request registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= StIdle;
      r_nxt   <= StIdle;
      r_last  <= 1'b0;
      r_wr    <= 1'b0;
      r_blk   <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_nxt   <= w_nxt;
      r_last  <= w_last;
      r_wr    <= w_wr;
      r_blk   <= w_blk;
      r_rem   <= w_rem;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  // pi1 command outputs decoded straight from the current state.
  always_comb begin
    pi_op_o   = OpNoop;
    pi_addr_o = '0;
    pi_data_o = '0;
    unique case (r_state)
      StStat: begin
        pi_op_o   = OpRw;
        pi_addr_o = CmdStatus;
      end
      StRead: begin
        pi_op_o   = OpRw;
        pi_addr_o = CmdRead;
        pi_data_o = r_blk;
      end
      StWrite: begin
        pi_op_o   = OpRw;
        pi_addr_o = CmdWrite;
        pi_data_o = r_blk;
      end
      StSwap: begin
        pi_op_o   = OpRw;
        pi_addr_o = CmdSwap;
      end
      default: pi_op_o = OpNoop;
    endcase
    pi_sel_o = (pi_op_o != OpNoop) ? '1 : '0;
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign blk_o     = r_blk;
  assign buf_rdy_o = (r_state == StBuf);

endmodule

// File: tb/tb_blkdev_seq.sv
// Directed bench for blkdev_seq: a reactive device model answers pi1 ops, a scoreboard
// holds the expected READ/WRITE/SWAP commands, and status words come from a queue.
module tb_blkdev_seq;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        req_wr_i;
  logic [31:0] req_blk_i;
  logic [15:0] req_cnt_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] blk_o;
  logic        buf_rdy_o;
  logic        buf_ack_i;
  logic [1:0]  pi_op_o;
  logic [29:0] pi_addr_o;
  logic [31:0] pi_data_o;
  logic [31:0] pi_data_i;
  logic [3:0]  pi_sel_o;
  logic        pi_rdy_i;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
  } cmd_t;

  cmd_t        exp_q[$];
  logic [31:0] stat_q[$];
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          op_cnt = 0;
  int          ack_dly = 3;
  bit          rd_hold = 1'b0;
  bit          stat_fire = 1'b0;

  blkdev_seq #(
    .ARCHBITSZ(32),
    .CNTBITSZ (16),
    .TIMEOUT  (8)
  ) u_dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .req_wr_i (req_wr_i),
    .req_blk_i(req_blk_i),
    .req_cnt_i(req_cnt_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .blk_o    (blk_o),
    .buf_rdy_o(buf_rdy_o),
    .buf_ack_i(buf_ack_i),
    .pi_op_o  (pi_op_o),
    .pi_addr_o(pi_addr_o),
    .pi_data_o(pi_data_o),
    .pi_data_i(pi_data_i),
    .pi_sel_o (pi_sel_o),
    .pi_rdy_i (pi_rdy_i)
  );

  always #5 clk = ~clk;

  // Zero-wait device, except READ can be stalled to test reset mid-command.
  assign pi_rdy_i = (pi_op_o != 2'b00) && !(rd_hold && pi_addr_o == 30'd2);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [29:0] addr, input logic [31:0] data);
    cmd_t c;
    c.addr = addr;
    c.data = data;
    exp_q.push_back(c);
  endtask

  task automatic do_req(input bit wr, input logic [31:0] blk, input logic [15:0] cnt);
    req_i     = 1'b1;
    req_wr_i  = wr;
    req_blk_i = blk;
    req_cnt_i = cnt;
    tick();
    req_i = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int wait_c = 0;
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < budget) begin
      tick();
      cyc++;
      buf_ack_i = 1'b0;
      if (buf_rdy_o) begin
        wait_c++;
        if (wait_c >= ack_dly) begin
          buf_ack_i = 1'b1;
          wait_c    = 0;
        end
      end
      if (done_o) seen = 1'b1;
    end
    buf_ack_i = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("busy_at_done", 64'(busy_o), 64'd0);
  endtask

  // Monitor: command scoreboard, pi_sel/op legality, done and op counting.
  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      chk("op_legal", 64'(pi_op_o == 2'b00 || pi_op_o == 2'b11), 64'd1);
      chk("sel", 64'(pi_sel_o), (pi_op_o != 2'b00) ? 64'hF : 64'h0);
      if (pi_op_o != 2'b00) op_cnt++;
      if (done_o) done_cnt++;
      if (pi_op_o != 2'b00 && pi_rdy_i) begin
        if (pi_addr_o == 30'd0) begin
          stat_fire = 1'b1;
        end else if (exp_q.size() == 0) begin
          chk("sb_underflow", 64'(pi_addr_o), 64'hFFFF);
        end else begin
          cmd_t c;
          c = exp_q.pop_front();
          chk("cmd_addr", 64'(pi_addr_o), 64'(c.addr));
          chk("cmd_data", 64'(pi_data_o), 64'(c.data));
        end
      end
    end
  end

  // Status source: consume one entry per completed STAT, default READY when empty.
  always @(posedge clk) begin
    #1;
    if (stat_fire) begin
      stat_fire = 1'b0;
      if (stat_q.size() > 0) void'(stat_q.pop_front());
    end
    pi_data_i = (stat_q.size() > 0) ? stat_q[0] : 32'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int o0;
    bit found;
    rst_i     = 1'b0;
    req_i     = 1'b0;
    req_wr_i  = 1'b0;
    req_blk_i = '0;
    req_cnt_i = '0;
    buf_ack_i = 1'b0;
    pi_data_i = 32'd1;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_buf", 64'(buf_rdy_o), 64'd0);
    chk("rst_blk", 64'(blk_o), 64'd0);
    chk("rst_op", 64'(pi_op_o), 64'd0);
    chk("rst_sel", 64'(pi_sel_o), 64'd0);
    chk("rst_addr", 64'(pi_addr_o), 64'd0);
    chk("rst_data", 64'(pi_data_o), 64'd0);
    rst_i = 1'b1;
    tick();

    // Read 2 blocks from 5, device always READY, buffer acked after 3 cycles
    push_cmd(30'd2, 32'd5);
    push_cmd(30'd1, 32'd0);
    push_cmd(30'd2, 32'd6);
    push_cmd(30'd1, 32'd0);
    d0 = done_cnt;
    do_req(1'b0, 32'd5, 16'd2);
    chk("rd_busy", 64'(busy_o), 64'd1);
    run_to_done(200);
    tick();
    chk("rd_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("rd_done_low", 64'(done_o), 64'd0);
    chk("rd_err", 64'(err_o), 64'd0);
    chk("rd_blk", 64'(blk_o), 64'd7);
    chk("rd_sb_empty", 64'(exp_q.size()), 64'd0);

    // Write 1 block to 9, status BUSY four times before READY
    stat_q.push_back(32'd0);
    stat_q.push_back(32'd2);
    stat_q.push_back(32'd0);
    stat_q.push_back(32'd2);
    push_cmd(30'd1, 32'd0);
    push_cmd(30'd3, 32'd9);
    d0 = done_cnt;
    do_req(1'b1, 32'd9, 16'd1);
    chk("wr_buf_first", 64'(buf_rdy_o), 64'd1);
    chk("wr_no_op", 64'(pi_op_o), 64'd0);
    run_to_done(200);
    tick();
    chk("wr_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("wr_err", 64'(err_o), 64'd0);
    chk("wr_blk", 64'(blk_o), 64'd10);
    chk("wr_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("wr_stat_used", 64'(stat_q.size()), 64'd0);

    // Read 3 from 20, status error on the second block's first poll
    stat_q.push_back(32'd1);
    stat_q.push_back(32'd1);
    stat_q.push_back(32'd3);
    push_cmd(30'd2, 32'd20);
    push_cmd(30'd1, 32'd0);
    d0 = done_cnt;
    do_req(1'b0, 32'd20, 16'd3);
    run_to_done(200);
    chk("er_err", 64'(err_o), 64'd1);
    tick();
    chk("er_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("er_err_sticky", 64'(err_o), 64'd1);
    chk("er_blk", 64'(blk_o), 64'd21);
    chk("er_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("er_stat_used", 64'(stat_q.size()), 64'd0);

    // Zero-count request: clears err, done two cycles later, no pi1 ops
    o0 = op_cnt;
    d0 = done_cnt;
    do_req(1'b0, 32'd100, 16'd0);
    chk("z_err_clr", 64'(err_o), 64'd0);
    chk("z_busy", 64'(busy_o), 64'd1);
    chk("z_done_early", 64'(done_o), 64'd0);
    tick();
    chk("z_done", 64'(done_o), 64'd1);
    chk("z_busy_drop", 64'(busy_o), 64'd0);
    tick();
    chk("z_done_once", 64'(done_cnt - d0), 64'd1);
    chk("z_no_ops", 64'(op_cnt - o0), 64'd0);
    chk("z_blk", 64'(blk_o), 64'd100);

    // Request while busy is ignored
    push_cmd(30'd2, 32'd30);
    push_cmd(30'd1, 32'd0);
    do_req(1'b0, 32'd30, 16'd1);
    do_req(1'b0, 32'd77, 16'd5);
    run_to_done(200);
    tick();
    chk("ign_blk", 64'(blk_o), 64'd31);
    chk("ign_sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset during a stalled READ abandons it
    rd_hold = 1'b1;
    do_req(1'b0, 32'd40, 16'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pi_op_o == 2'b11 && pi_addr_o == 30'd2) found = 1'b1;
      else tick();
    end
    chk("rs_read_reached", 64'(found), 64'd1);
    chk("rs_read_data", 64'(pi_data_o), 64'd40);
    rst_i = 1'b0;
    tick();
    rst_i   = 1'b1;
    rd_hold = 1'b0;
    chk("rs_op", 64'(pi_op_o), 64'd0);
    chk("rs_busy", 64'(busy_o), 64'd0);
    chk("rs_blk", 64'(blk_o), 64'd0);
    tick();
    chk("rs_no_retry", 64'(pi_op_o), 64'd0);
    push_cmd(30'd2, 32'd41);
    push_cmd(30'd1, 32'd0);
    do_req(1'b0, 32'd41, 16'd1);
    run_to_done(200);
    tick();
    chk("rs_restart_blk", 64'(blk_o), 64'd42);
    chk("rs_restart_err", 64'(err_o), 64'd0);
    chk("rs_sb_empty", 64'(exp_q.size()), 64'd0);

`ifdef BLKDEV_SEQ_TIMEOUT_EN
    // Status stuck at 0: error after TIMEOUT polls
    for (int i = 0; i < 20; i++) stat_q.push_back(32'd0);
    tick();
    do_req(1'b0, 32'd60, 16'd1);
    run_to_done(50);
    chk("to_err", 64'(err_o), 64'd1);
    chk("to_polls", 64'(stat_q.size()), 64'd12);
    chk("to_sb_empty", 64'(exp_q.size()), 64'd0);
    stat_q.delete();
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
